collision_scanner: RTL and testbench

Parametrised, sequential successor to the single-pass collision checker. It sweeps the entity file one slot per clock and evaluates a proposed move against the play-field bounds and every active entity. It then returns the accepted position, game-over/win flags and the first hit slot. It sits between the position-update FSM (START/DONE handshake) and the synchronous entity-file RAM (one-cycle read latency).

---
 rtl/collision_scanner.sv | 210 +++++++++++++++++++++
 tb/tb_collision_scanner.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scanner.sv
// collision_scanner: sweeps the entity file one slot per clock and judges a
// proposed move against the play-field bounds and every active entity.
module collision_scanner #(
    parameter int unsigned COORD_W      = 9,
    parameter int unsigned N_ENT        = 8,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned HIT_DIST     = 28,
    parameter int unsigned X_MIN        = 32,
    parameter int unsigned X_MAX        = 255,
    parameter int unsigned Y_MIN        = 32,
    parameter int unsigned Y_MAX        = 191,
    parameter bit          STICKY_FLAGS = 1'b1
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               START,
    input  logic [ADDR_W-1:0]  MOVER_ADDR,
    input  logic [1:0]         MOVER_ID,
    input  logic [COORD_W-1:0] OLD_X,
    input  logic [COORD_W-1:0] OLD_Y,
    input  logic [COORD_W-1:0] NEW_X,
    input  logic [COORD_W-1:0] NEW_Y,
    output logic [ADDR_W-1:0]  ADDRESS,
    input  logic               OBJ_VALID,
    input  logic [1:0]         OBJ_ID,
    input  logic [COORD_W-1:0] OBJ_X,
    input  logic [COORD_W-1:0] OBJ_Y,
    output logic               BUSY,
    output logic               DONE,
    output logic [COORD_W-1:0] FINAL_X,
    output logic [COORD_W-1:0] FINAL_Y,
    output logic               BLOCKED,
    output logic               GAME_OVER_FLAG,
    output logic               YOU_WIN_FLAG,
    output logic               HIT_VALID,
    output logic [ADDR_W-1:0]  HIT_ADDR
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StScan   = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StReport = 2'd3;

    localparam logic [ADDR_W-1:0]  LastAddr = ADDR_W'(N_ENT - 1);
    localparam logic [COORD_W:0]   HitDist  = (COORD_W + 1)'(HIT_DIST);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    // Mover request latched at START so the requester may move on.
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [1:0]         m_id_q, m_id_d;
    logic [COORD_W-1:0] old_x_q, old_x_d, old_y_q, old_y_d;
    logic [COORD_W-1:0] new_x_q, new_x_d, new_y_q, new_y_d;
    // Scan accumulators.
    logic               blk_q, blk_d, over_q, over_d, win_q, win_d;
    logic               hv_q, hv_d;
    logic [ADDR_W-1:0]  ha_q, ha_d;
    // Result registers, held between DONE pulses.
    logic [COORD_W-1:0] fx_q, fx_d, fy_q, fy_d;
    logic               blocked_q, blocked_d, go_q, go_d, yw_q, yw_d;
    logic               hit_valid_q, hit_valid_d;
    logic [ADDR_W-1:0]  hit_addr_q, hit_addr_d;

    logic                eval_en, active, overlap, oob;
    logic [ADDR_W-1:0]   eval_slot;
    logic signed [COORD_W:0] dx_s, dy_s;
    logic [COORD_W:0]    adx, ady;
    logic                slot_blk, slot_win, slot_over;

    // Per-slot judgement: RAM data in this cycle belongs to last cycle's address.
    always_comb begin
        eval_en   = ((state_q == StScan) && (addr_q != '0)) || (state_q == StDrain);
        eval_slot = (state_q == StDrain) ? addr_q : addr_q - ADDR_W'(1);
        active    = eval_en && OBJ_VALID && (eval_slot != m_addr_q);
        dx_s      = $signed({1'b0, new_x_q}) - $signed({1'b0, OBJ_X});
        dy_s      = $signed({1'b0, new_y_q}) - $signed({1'b0, OBJ_Y});
        adx       = dx_s[COORD_W] ? $unsigned(-dx_s) : $unsigned(dx_s);
        ady       = dy_s[COORD_W] ? $unsigned(-dy_s) : $unsigned(dy_s);
        overlap   = active && (adx < HitDist) && (ady < HitDist);
        slot_blk  = overlap && (OBJ_ID == 2'd3);
        slot_win  = overlap && (OBJ_ID == 2'd2) && (m_id_q != 2'd2);
        slot_over = overlap && !OBJ_ID[1] && (OBJ_ID != m_id_q);
        oob       = (new_x_q < COORD_W'(X_MIN)) || (new_x_q > COORD_W'(X_MAX)) ||
                    (new_y_q < COORD_W'(Y_MIN)) || (new_y_q > COORD_W'(Y_MAX));
    end

    // Next-state logic for the sweep FSM, accumulators and result registers.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        m_addr_d    = m_addr_q;
        m_id_d      = m_id_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        blk_d       = blk_q | slot_blk;
        over_d      = over_q | slot_over;
        win_d       = win_q | slot_win;
        hv_d        = hv_q | overlap;
        ha_d        = (overlap && !hv_q) ? eval_slot : ha_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        blocked_d   = blocked_q;
        go_d        = go_q;
        yw_d        = yw_q;
        hit_valid_d = hit_valid_q;
        hit_addr_d  = hit_addr_q;
        case (state_q)
            StIdle: begin
                addr_d = '0;
                if (START) begin
                    m_addr_d = MOVER_ADDR;
                    m_id_d   = MOVER_ID;
                    old_x_d  = OLD_X;
                    old_y_d  = OLD_Y;
                    new_x_d  = NEW_X;
                    new_y_d  = NEW_Y;
                    blk_d    = 1'b0;
                    over_d   = 1'b0;
                    win_d    = 1'b0;
                    hv_d     = 1'b0;
                    ha_d     = '0;
                    state_d  = StScan;
                end
            end
            StScan: begin
                if (addr_q == LastAddr) begin
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                // The last slot is folded in here so REPORT sees the full scan.
                blocked_d   = blk_d | oob;
                fx_d        = (blk_d | oob) ? old_x_q : new_x_q;
                fy_d        = (blk_d | oob) ? old_y_q : new_y_q;
                go_d        = STICKY_FLAGS ? (go_q | over_d) : over_d;
                yw_d        = STICKY_FLAGS ? (yw_q | win_d) : win_d;
                hit_valid_d = hv_d;
                hit_addr_d  = ha_d;
                addr_d      = '0;
                state_d     = StReport;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            m_addr_q    <= '0;
            m_id_q      <= '0;
            old_x_q     <= '0;
            old_y_q     <= '0;
            new_x_q     <= '0;
            new_y_q     <= '0;
            blk_q       <= 1'b0;
            over_q      <= 1'b0;
            win_q       <= 1'b0;
            hv_q        <= 1'b0;
            ha_q        <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
            blocked_q   <= 1'b0;
            go_q        <= 1'b0;
            yw_q        <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            m_addr_q    <= m_addr_d;
            m_id_q      <= m_id_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            blk_q       <= blk_d;
            over_q      <= over_d;
            win_q       <= win_d;
            hv_q        <= hv_d;
            ha_q        <= ha_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            blocked_q   <= blocked_d;
            go_q        <= go_d;
            yw_q        <= yw_d;
            hit_valid_q <= hit_valid_d;
            hit_addr_q  <= hit_addr_d;
        end
    end

    assign ADDRESS        = addr_q;
    assign BUSY           = (state_q != StIdle);
    assign DONE           = (state_q == StReport);
    assign FINAL_X        = fx_q;
    assign FINAL_Y        = fy_q;
    assign BLOCKED        = blocked_q;
    assign GAME_OVER_FLAG = go_q;
    assign YOU_WIN_FLAG   = yw_q;
    assign HIT_VALID      = hit_valid_q;
    assign HIT_ADDR       = hit_addr_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: sticky and non-sticky instances share stimulus
// and are checked every cycle against a move-judging reference model.
module tb_collision_scanner;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       RESET, START;
    logic [2:0] MOVER_ADDR;
    logic [1:0] MOVER_ID;
    logic [8:0] OLD_X, OLD_Y, NEW_X, NEW_Y;

    // Entity-file contents and per-instance synchronous read ports.
    logic       mem_v [N];
    logic [1:0] mem_id[N];
    logic [8:0] mem_x [N];
    logic [8:0] mem_y [N];

    logic [2:0] addr_s, addr_n, ha_s, ha_n;
    logic       ov_s, ov_n;
    logic [1:0] oid_s, oid_n;
    logic [8:0] ox_s, oy_s, ox_n, oy_n;
    logic       busy_s, busy_n, done_s, done_n, blk_s, blk_n;
    logic       go_s, go_n, yw_s, yw_n, hv_s, hv_n;
    logic [8:0] fx_s, fy_s, fx_n, fy_n;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    collision_scanner #(.STICKY_FLAGS(1'b1)) dut_s (
        .CLOCK_50(clk), .RESET(RESET), .START(START), .MOVER_ADDR(MOVER_ADDR),
        .MOVER_ID(MOVER_ID), .OLD_X(OLD_X), .OLD_Y(OLD_Y), .NEW_X(NEW_X), .NEW_Y(NEW_Y),
        .ADDRESS(addr_s), .OBJ_VALID(ov_s), .OBJ_ID(oid_s), .OBJ_X(ox_s), .OBJ_Y(oy_s),
        .BUSY(busy_s), .DONE(done_s), .FINAL_X(fx_s), .FINAL_Y(fy_s), .BLOCKED(blk_s),
        .GAME_OVER_FLAG(go_s), .YOU_WIN_FLAG(yw_s), .HIT_VALID(hv_s), .HIT_ADDR(ha_s)
    );

    collision_scanner #(.STICKY_FLAGS(1'b0)) dut_n (
        .CLOCK_50(clk), .RESET(RESET), .START(START), .MOVER_ADDR(MOVER_ADDR),
        .MOVER_ID(MOVER_ID), .OLD_X(OLD_X), .OLD_Y(OLD_Y), .NEW_X(NEW_X), .NEW_Y(NEW_Y),
        .ADDRESS(addr_n), .OBJ_VALID(ov_n), .OBJ_ID(oid_n), .OBJ_X(ox_n), .OBJ_Y(oy_n),
        .BUSY(busy_n), .DONE(done_n), .FINAL_X(fx_n), .FINAL_Y(fy_n), .BLOCKED(blk_n),
        .GAME_OVER_FLAG(go_n), .YOU_WIN_FLAG(yw_n), .HIT_VALID(hv_n), .HIT_ADDR(ha_n)
    );

    always @(posedge clk) begin
        ov_s <= mem_v[addr_s]; oid_s <= mem_id[addr_s]; ox_s <= mem_x[addr_s]; oy_s <= mem_y[addr_s];
        ov_n <= mem_v[addr_n]; oid_n <= mem_id[addr_n]; ox_n <= mem_x[addr_n]; oy_n <= mem_y[addr_n];
    end

    typedef struct packed {
        logic [8:0] fx;
        logic [8:0] fy;
        logic       blk;
        logic       go;
        logic       yw;
        logic       hv;
        logic [2:0] ha;
    } res_t;

    // Whole-move verdict from the game rules over the current entity file.
    function automatic res_t judge(int maddr, int mid, int ox, int oy, int nx, int ny);
        res_t r;
        int dx, dy, id;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (!mem_v[k] || k == maddr) continue;
            dx = nx - int'(mem_x[k]);
            dy = ny - int'(mem_y[k]);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (dx < 28 && dy < 28) begin
                if (!r.hv) begin
                    r.hv = 1'b1;
                    r.ha = 3'(k);
                end
                id = int'(mem_id[k]);
                if (id == 3) r.blk = 1'b1;
                else if (id == 2 && mid != 2) r.yw = 1'b1;
                else if (id < 2 && id != mid) r.go = 1'b1;
            end
        end
        if (nx < 32 || nx > 255 || ny < 32 || ny > 191) r.blk = 1'b1;
        r.fx = r.blk ? 9'(ox) : 9'(ny == ny ? nx : nx);
        r.fy = r.blk ? 9'(oy) : 9'(ny);
        return r;
    endfunction

    // Model: c counts cycles since START acceptance (0 = idle).
    int   c = 0;
    res_t pend, e;
    logic e_go_s, e_yw_s, e_go_n, e_yw_n;

    always @(posedge clk) begin
        if (RESET) begin
            c = 0;
            e = '0;
            e_go_s = 1'b0; e_yw_s = 1'b0; e_go_n = 1'b0; e_yw_n = 1'b0;
        end else if (c == 0) begin
            if (START) begin
                pend = judge(int'(MOVER_ADDR), int'(MOVER_ID), int'(OLD_X), int'(OLD_Y),
                             int'(NEW_X), int'(NEW_Y));
                c = 1;
            end
        end else if (c == N + 2) begin
            c = 0;
        end else begin
            c++;
            if (c == N + 2) begin
                e = pend;
                e_go_s = e_go_s | pend.go;
                e_yw_s = e_yw_s | pend.yw;
                e_go_n = pend.go;
                e_yw_n = pend.yw;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("busy_s", 32'(busy_s), 32'(c != 0));
            chk("busy_n", 32'(busy_n), 32'(c != 0));
            chk("done_s", 32'(done_s), 32'(c == N + 2));
            chk("done_n", 32'(done_n), 32'(c == N + 2));
            if (c == 0) begin
                chk("addr_s", 32'(addr_s), 0);
            end else if (c <= N) begin
                chk("addr_s", 32'(addr_s), 32'(c - 1));
                chk("addr_n", 32'(addr_n), 32'(c - 1));
            end else if (c == N + 1) begin
                chk("addr_s", 32'(addr_s), 32'(N - 1));
            end
            chk("final_x_s", 32'(fx_s), 32'(e.fx));
            chk("final_y_s", 32'(fy_s), 32'(e.fy));
            chk("final_x_n", 32'(fx_n), 32'(e.fx));
            chk("blocked_s", 32'(blk_s), 32'(e.blk));
            chk("blocked_n", 32'(blk_n), 32'(e.blk));
            chk("hit_valid_s", 32'(hv_s), 32'(e.hv));
            chk("hit_addr_s", 32'(ha_s), 32'(e.ha));
            chk("hit_addr_n", 32'(ha_n), 32'(e.ha));
            chk("game_over_s", 32'(go_s), 32'(e_go_s));
            chk("you_win_s", 32'(yw_s), 32'(e_yw_s));
            chk("game_over_n", 32'(go_n), 32'(e_go_n));
            chk("you_win_n", 32'(yw_n), 32'(e_yw_n));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_move(input int ma, input int mi, input int ox, input int oy,
                            input int nx, input int ny);
        MOVER_ADDR = 3'(ma); MOVER_ID = 2'(mi);
        OLD_X = 9'(ox); OLD_Y = 9'(oy); NEW_X = 9'(nx); NEW_Y = 9'(ny);
    endtask

    task automatic set_slot(input int k, input logic v, input int id, input int x, input int y);
        mem_v[k] = v; mem_id[k] = 2'(id); mem_x[k] = 9'(x); mem_y[k] = 9'(y);
    endtask

    // Called in an idle cycle just after a clock edge; returns in the DONE cycle.
    task automatic run_scan(output int lat);
        START = 1'b1;
        step();
        START = 1'b0;
        lat = 0;
        while (done_s !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        if (lat >= 40) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no DONE expected DONE within 40 cycles");
        end
    endtask

    int lat, ndone;

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        set_move(0, 0, 100, 100, 104, 100);
        for (int k = 0; k < N; k++) set_slot(k, 1'b0, 0, 0, 0);
        repeat (3) step();
        RESET = 1'b0;
        chk("reset_final_x", 32'(fx_s), 0);
        chk("reset_busy", 32'(busy_s), 0);
        chk_en = 1'b1;
        step();

        // Empty field, legal move.
        run_scan(lat);
        chk("latency", 32'(lat), 32'(N + 1));
        chk("t1_final_x", 32'(fx_s), 104);
        chk("t1_blocked", 32'(blk_s), 0);
        chk("t1_hit_valid", 32'(hv_s), 0);
        step();

        // Out of bounds on X.
        set_move(0, 0, 100, 100, 30, 100);
        run_scan(lat);
        chk("t2_blocked", 32'(blk_s), 1);
        chk("t2_final_x", 32'(fx_s), 100);
        chk("t2_game_over", 32'(go_s), 0);

        // Inclusive upper corner, started back-to-back after DONE.
        step();
        set_move(0, 0, 100, 100, 255, 191);
        run_scan(lat);
        chk("b2b_gap", 32'(lat + 2), 32'(N + 3));
        chk("t3_final_x", 32'(fx_s), 255);
        chk("t3_final_y", 32'(fy_s), 191);
        chk("t3_blocked", 32'(blk_s), 0);
        step();

        // Wall just inside the hit distance.
        set_slot(5, 1'b1, 3, 131, 100);
        set_move(0, 0, 100, 100, 104, 100);
        run_scan(lat);
        chk("t4_blocked", 32'(blk_s), 1);
        chk("t4_hit_addr", 32'(ha_s), 5);
        chk("t4_final_x", 32'(fx_s), 100);
        step();

        // Wall exactly at the hit distance.
        mem_x[5] = 9'd132;
        run_scan(lat);
        chk("t5_blocked", 32'(blk_s), 0);
        chk("t5_hit_valid", 32'(hv_s), 0);
        step();

        // Actor and goal both overlapping; mover's own slot overlaps too.
        mem_v[5] = 1'b0;
        set_slot(0, 1'b1, 0, 100, 100);
        set_slot(2, 1'b1, 1, 110, 110);
        set_slot(6, 1'b1, 2, 90, 95);
        run_scan(lat);
        chk("t6_game_over", 32'(go_s), 1);
        chk("t6_you_win", 32'(yw_s), 1);
        chk("t6_hit_addr", 32'(ha_s), 2);
        chk("t6_final_x", 32'(fx_s), 104);
        step();

        // Only a same-ID actor overlaps: hit recorded, no new flags.
        mem_v[2] = 1'b0;
        mem_v[6] = 1'b0;
        set_slot(3, 1'b1, 0, 120, 100);
        run_scan(lat);
        chk("t7_sticky_go", 32'(go_s), 1);
        chk("t7_nonsticky_go", 32'(go_n), 0);
        chk("t7_nonsticky_win", 32'(yw_n), 0);
        chk("t7_hit_addr", 32'(ha_s), 3);
        step();

        // Reset in the middle of a scan.
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (3) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("t8_busy", 32'(busy_s), 0);
        chk("t8_game_over", 32'(go_s), 0);
        chk("t8_hit_valid", 32'(hv_s), 0);
        ndone = 0;
        repeat (15) begin
            step();
            if (done_s === 1'b1) ndone++;
        end
        chk("t8_no_done", 32'(ndone), 0);

        // Second START while busy is dropped.
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        START = 1'b1;
        step();
        START = 1'b0;
        ndone = 0;
        repeat (20) begin
            step();
            if (done_s === 1'b1) ndone++;
        end
        chk("t9_one_done", 32'(ndone), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
